// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, fixed-latency memory between the instruction
// fetch stage (IF_*) and the data stage (D_*) of the pipelined MIPS core.
// One access is in flight at a time. Each access walks the sequence
// IDLE (grant) -> ISSUE (Mem_Req strobe) -> WAIT (count down to read data)
// -> RESP (one-cycle Ack). When both stages request in the same IDLE cycle,
// the stage that was not served last wins, so neither can starve the other.
//
// Parameters
//   MEM_LAT   memory read latency: cycles from the Mem_Req cycle to the
//             cycle Mem_Rdata is valid. Legal range 1..15.
//
// Ports
//   CLK, RESET            clock; synchronous active-high reset
//   IF_Req/IF_Addr        fetch request (always a read), held until IF_Ack
//   IF_Ack/IF_Rdata       one-cycle completion pulse with fetched word
//   D_Req/D_We/D_Addr/D_Wdata  data request (load or store), held until D_Ack
//   D_Ack/D_Rdata         one-cycle completion pulse; D_Rdata moves on loads only
//   IF_Stall, MEM_Stall   per-stage stall = Req & ~Ack
//   Mem_Req               one-cycle issue strobe to the memory
//   Mem_We/Mem_Addr/Mem_Wdata  access attributes, meaningful while Mem_Req
//   Mem_Rdata             read data, valid MEM_LAT cycles after Mem_Req
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IF_Req,
    input  logic [31:0] IF_Addr,
    output logic        IF_Ack,
    output logic [31:0] IF_Rdata,
    input  logic        D_Req,
    input  logic        D_We,
    input  logic [31:0] D_Addr,
    input  logic [31:0] D_Wdata,
    output logic        D_Ack,
    output logic [31:0] D_Rdata,
    output logic        IF_Stall,
    output logic        MEM_Stall,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_Wdata,
    input  logic [31:0] Mem_Rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Counter is loaded in ISSUE and reads 0 in the cycle Mem_Rdata is valid.
    // With MEM_LAT = 1 the load value is 0, so the first WAIT cycle is
    // already the capture cycle.
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    logic [1:0] state;
    logic       owner;
    logic       last_owner;
    logic [3:0] cnt;
    logic       req_any;
    logic       next_owner;

    assign req_any = IF_Req | D_Req;

    // Single requester always wins; on a conflict the stage that was not
    // served last goes first. last_owner resets to IF, so D wins the first
    // conflict after reset.
    always_comb begin
        next_owner = D_Req ? OWN_D : OWN_IF;
        if (IF_Req && D_Req) begin
            next_owner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
        end
    end

    // Ack is registered, so a stall drops exactly in the Ack cycle.
    assign IF_Stall  = IF_Req & ~IF_Ack;
    assign MEM_Stall = D_Req  & ~D_Ack;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            cnt        <= 4'd0;
            Mem_Req    <= 1'b0;
            Mem_We     <= 1'b0;
            Mem_Addr   <= 32'h0;
            Mem_Wdata  <= 32'h0;
            IF_Ack     <= 1'b0;
            IF_Rdata   <= 32'h0;
            D_Ack      <= 1'b0;
            D_Rdata    <= 32'h0;
        end else begin
            // Strobes are single-cycle by default.
            Mem_Req <= 1'b0;
            IF_Ack  <= 1'b0;
            D_Ack   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        owner   <= next_owner;
                        Mem_Req <= 1'b1;
                        if (next_owner == OWN_D) begin
                            Mem_We    <= D_We;
                            Mem_Addr  <= D_Addr;
                            Mem_Wdata <= D_Wdata;
                        end else begin
                            // Fetches are reads; Mem_Wdata keeps its old
                            // value since it is ignored when Mem_We is low.
                            Mem_We    <= 1'b0;
                            Mem_Addr  <= IF_Addr;
                        end
                        state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    cnt   <= CNT_LOAD;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        if (owner == OWN_D) begin
                            D_Ack <= 1'b1;
                            // Stores complete with the same timing but leave
                            // the last load result visible.
                            if (!Mem_We) begin
                                D_Rdata <= Mem_Rdata;
                            end
                        end else begin
                            IF_Ack   <= 1'b1;
                            IF_Rdata <= Mem_Rdata;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                S_RESP: begin
                    // Ack is high this cycle; no new grant until IDLE, so the
                    // acked requester's still-high Req is not re-served here.
                    last_owner <= owner;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. Requester drivers push expected responses into
// scoreboard queues when they raise a request; a monitor pops and compares
// whenever the DUT acks. A behavioural memory answers Mem_Req after exactly
// LAT cycles and drives random data in every other cycle. Two extra
// instances built with MEM_LAT = 1 and 15 cover the latency extremes.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam int TMO = 4 * LAT + 40;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } issue_t;

    typedef struct {
        int cyc;
        bit is_d;
    } ack_t;

    typedef struct {
        bit          we;
        logic [31:0] data;
    } dexp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    logic        CLK;
    logic        RESET;
    logic        IF_Req;
    logic [31:0] IF_Addr;
    logic        IF_Ack;
    logic [31:0] IF_Rdata;
    logic        D_Req;
    logic        D_We;
    logic [31:0] D_Addr;
    logic [31:0] D_Wdata;
    logic        D_Ack;
    logic [31:0] D_Rdata;
    logic        IF_Stall;
    logic        MEM_Stall;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_Wdata;
    logic [31:0] Mem_Rdata;

    // extra instances (index 0: MEM_LAT=1, index 1: MEM_LAT=15)
    logic        x_req   [2];
    logic [31:0] x_addr;
    logic [31:0] x_mem_rdata;
    logic        x_ack   [2];
    logic [31:0] x_rdata [2];
    logic        x_dack  [2];
    logic [31:0] x_drdata[2];
    logic        x_istall[2];
    logic        x_mstall[2];
    logic        x_mreq  [2];
    logic        x_mwe   [2];
    logic [31:0] x_maddr [2];
    logic [31:0] x_mwdata[2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] ref_mem [1024];   // reference: what the memory should hold
    logic [31:0] dev_mem [1024];   // contents of the behavioural memory
    logic [31:0] if_exp  [$];
    dexp_t       d_exp   [$];
    pend_t       pend_q  [$];
    issue_t      issue_log[$];
    ack_t        ack_log [$];
    logic [31:0] d_rdata_model = 32'h0;
    int          if_stall_cnt  = 0;
    logic        prev_if_req = 1'b0, prev_if_ack = 1'b0;
    logic        prev_d_req  = 1'b0, prev_d_ack  = 1'b0;
    logic        prev_mem_req = 1'b0;

    mem_port_arbiter #(.MEM_LAT(LAT)) dut (
        .CLK(CLK), .RESET(RESET),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Ack(IF_Ack), .IF_Rdata(IF_Rdata),
        .D_Req(D_Req), .D_We(D_We), .D_Addr(D_Addr), .D_Wdata(D_Wdata),
        .D_Ack(D_Ack), .D_Rdata(D_Rdata),
        .IF_Stall(IF_Stall), .MEM_Stall(MEM_Stall),
        .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
        .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata)
    );

    mem_port_arbiter #(.MEM_LAT(1)) dut_l1 (
        .CLK(CLK), .RESET(RESET),
        .IF_Req(x_req[0]), .IF_Addr(x_addr), .IF_Ack(x_ack[0]), .IF_Rdata(x_rdata[0]),
        .D_Req(1'b0), .D_We(1'b0), .D_Addr(32'h0), .D_Wdata(32'h0),
        .D_Ack(x_dack[0]), .D_Rdata(x_drdata[0]),
        .IF_Stall(x_istall[0]), .MEM_Stall(x_mstall[0]),
        .Mem_Req(x_mreq[0]), .Mem_We(x_mwe[0]), .Mem_Addr(x_maddr[0]),
        .Mem_Wdata(x_mwdata[0]), .Mem_Rdata(x_mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(15)) dut_l15 (
        .CLK(CLK), .RESET(RESET),
        .IF_Req(x_req[1]), .IF_Addr(x_addr), .IF_Ack(x_ack[1]), .IF_Rdata(x_rdata[1]),
        .D_Req(1'b0), .D_We(1'b0), .D_Addr(32'h0), .D_Wdata(32'h0),
        .D_Ack(x_dack[1]), .D_Rdata(x_drdata[1]),
        .IF_Stall(x_istall[1]), .MEM_Stall(x_mstall[1]),
        .Mem_Req(x_mreq[1]), .Mem_We(x_mwe[1]), .Mem_Addr(x_maddr[1]),
        .Mem_Wdata(x_mwdata[1]), .Mem_Rdata(x_mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic ceq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk(nm, act === exp, act, exp);
    endtask

    // Behavioural memory: serve each issue, answer reads exactly LAT cycles
    // after the Mem_Req cycle, random data in every other cycle.
    always @(negedge CLK) begin
        if (RESET) begin
            pend_q.delete();
        end else if (Mem_Req) begin
            if (Mem_We) dev_mem[Mem_Addr[11:2]] = Mem_Wdata;
            else        pend_q.push_back('{cyc + LAT, dev_mem[Mem_Addr[11:2]]});
        end
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            Mem_Rdata = pend_q[0].data;
            void'(pend_q.pop_front());
        end else begin
            Mem_Rdata = $urandom;
        end
    end

    // Monitor / scoreboard
    always @(negedge CLK) begin : monitor
        logic [31:0] e;
        dexp_t       de;
        bit          ok;
        if (!RESET) begin
            ceq("if_stall", {31'h0, IF_Stall}, {31'h0, IF_Req & ~IF_Ack});
            ceq("mem_stall", {31'h0, MEM_Stall}, {31'h0, D_Req & ~D_Ack});
            if (IF_Stall) if_stall_cnt++;
            if (Mem_Req) begin
                issue_log.push_back('{cyc, Mem_Addr, Mem_We, Mem_Wdata});
                ok = (IF_Req && !Mem_We && Mem_Addr == IF_Addr) ||
                     (D_Req && Mem_We == D_We && Mem_Addr == D_Addr &&
                      (!D_We || Mem_Wdata == D_Wdata));
                chk("issue_match", ok, Mem_Addr, D_Req ? D_Addr : IF_Addr);
                chk("issue_single_cycle", !prev_mem_req, {31'h0, prev_mem_req}, 32'h0);
            end
            if (IF_Ack && D_Ack) chk("both_acks", 1'b0, 32'h1, 32'h0);
            if (IF_Ack) begin
                ack_log.push_back('{cyc, 1'b0});
                if (if_exp.size() == 0) begin
                    chk("if_unexpected_ack", 1'b0, 32'h1, 32'h0);
                end else begin
                    e = if_exp.pop_front();
                    ceq("if_rdata", IF_Rdata, e);
                end
            end
            if (D_Ack) begin
                ack_log.push_back('{cyc, 1'b1});
                if (d_exp.size() == 0) begin
                    chk("d_unexpected_ack", 1'b0, 32'h1, 32'h0);
                end else begin
                    de = d_exp.pop_front();
                    if (de.we) begin
                        ceq("d_store_rdata_kept", D_Rdata, d_rdata_model);
                    end else begin
                        ceq("d_load_rdata", D_Rdata, de.data);
                        d_rdata_model = de.data;
                    end
                end
            end
            if (prev_if_req && !prev_if_ack && !IF_Req)
                chk("if_req_dropped", 1'b0, 32'h0, 32'h1);
            if (prev_d_req && !prev_d_ack && !D_Req)
                chk("d_req_dropped", 1'b0, 32'h0, 32'h1);
        end
        prev_if_req  = IF_Req;
        prev_if_ack  = IF_Ack;
        prev_d_req   = D_Req;
        prev_d_ack   = D_Ack;
        prev_mem_req = Mem_Req;
    end

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET  = 1'b1;
        IF_Req = 1'b0;
        D_Req  = 1'b0;
        if_exp.delete();
        d_exp.delete();
        d_rdata_model = 32'h0;
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        ceq({tag, "_mem_req"},   {31'h0, Mem_Req}, 32'h0);
        ceq({tag, "_mem_we"},    {31'h0, Mem_We},  32'h0);
        ceq({tag, "_mem_addr"},  Mem_Addr,  32'h0);
        ceq({tag, "_mem_wdata"}, Mem_Wdata, 32'h0);
        ceq({tag, "_if_ack"},    {31'h0, IF_Ack},  32'h0);
        ceq({tag, "_d_ack"},     {31'h0, D_Ack},   32'h0);
        ceq({tag, "_if_rdata"},  IF_Rdata,  32'h0);
        ceq({tag, "_d_rdata"},   D_Rdata,   32'h0);
    endtask

    // Raise (or re-raise) a fetch; returns in the Ack cycle with Req still high.
    task automatic if_fetch(input logic [31:0] a, output int t0, output int lat);
        @(posedge CLK); #1;
        IF_Req  = 1'b1;
        IF_Addr = a;
        if_exp.push_back(ref_mem[a[11:2]]);
        t0  = cyc;
        lat = -1;
        for (int k = 0; k < TMO; k++) begin
            @(negedge CLK);
            if (IF_Ack) begin
                lat = cyc - t0;
                break;
            end
        end
        if (lat < 0) begin
            chk("if_ack_timeout", 1'b0, 32'h0, 32'h1);
            IF_Req = 1'b0;
        end
    endtask

    task automatic d_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                            output int t0, output int lat);
        @(posedge CLK); #1;
        D_Req   = 1'b1;
        D_We    = we;
        D_Addr  = a;
        D_Wdata = wd;
        if (we) begin
            ref_mem[a[11:2]] = wd;
            d_exp.push_back('{1'b1, wd});
        end else begin
            d_exp.push_back('{1'b0, ref_mem[a[11:2]]});
        end
        t0  = cyc;
        lat = -1;
        for (int k = 0; k < TMO; k++) begin
            @(negedge CLK);
            if (D_Ack) begin
                lat = cyc - t0;
                break;
            end
        end
        if (lat < 0) begin
            chk("d_ack_timeout", 1'b0, 32'h0, 32'h1);
            D_Req = 1'b0;
        end
    endtask

    task automatic if_idle(input int n);
        @(posedge CLK); #1;
        IF_Req = 1'b0;
        repeat (n - 1) @(posedge CLK);
    endtask

    task automatic d_idle(input int n);
        @(posedge CLK); #1;
        D_Req = 1'b0;
        repeat (n - 1) @(posedge CLK);
    endtask

    initial begin
        int t0, lat, t0d, latd;
        int xlat[2];
        bit xdone[2];
        bit exp_owner[4];

        RESET  = 1'b1;
        IF_Req = 1'b0; IF_Addr = 32'h0;
        D_Req  = 1'b0; D_We = 1'b0; D_Addr = 32'h0; D_Wdata = 32'h0;
        x_req[0] = 1'b0; x_req[1] = 1'b0; x_addr = 32'h0;
        x_mem_rdata = 32'h2008_0005;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[16] = 32'h2008_0005;   // word at 0x40
        dev_mem[16] = 32'h2008_0005;

        // reset state
        do_reset();
        @(negedge CLK);
        check_reset_vals("reset");

        // single fetch from 0x40
        issue_log.delete();
        if_stall_cnt = 0;
        if_fetch(32'h40, t0, lat);
        ceq("fetch_latency", lat, LAT + 2);
        ceq("fetch_rdata", IF_Rdata, 32'h2008_0005);
        ceq("fetch_issue_cnt", issue_log.size(), 1);
        if (issue_log.size() >= 1) begin
            ceq("fetch_issue_cyc", issue_log[0].cyc - t0, 1);
            ceq("fetch_issue_addr", issue_log[0].addr, 32'h40);
            ceq("fetch_issue_we", {31'h0, issue_log[0].we}, 32'h0);
        end
        ceq("fetch_stall_cycles", if_stall_cnt, LAT + 2);
        if_idle(2);

        // store DEADBEEF to 0x100
        issue_log.delete();
        d_access(1'b1, 32'h100, 32'hDEAD_BEEF, t0, lat);
        ceq("store_latency", lat, LAT + 2);
        ceq("store_rdata_unchanged", D_Rdata, 32'h0);
        if (issue_log.size() >= 1) begin
            ceq("store_issue_cyc", issue_log[0].cyc - t0, 1);
            ceq("store_issue_we", {31'h0, issue_log[0].we}, 32'h1);
            ceq("store_issue_addr", issue_log[0].addr, 32'h100);
            ceq("store_issue_wdata", issue_log[0].wdata, 32'hDEAD_BEEF);
        end else begin
            chk("store_issue_cnt", 1'b0, 32'h0, 32'h1);
        end
        d_idle(2);

        // conflict right after reset: data goes first
        do_reset();
        issue_log.delete();
        if_stall_cnt = 0;
        fork
            begin d_access(1'b0, 32'h200, 32'h0, t0d, latd); d_idle(1); end
            begin if_fetch(32'h44, t0, lat); if_idle(1); end
        join
        ceq("conflict_same_start", t0d, t0);
        ceq("conflict_d_latency", latd, LAT + 2);
        ceq("conflict_if_latency", lat, 2 * LAT + 5);
        ceq("conflict_if_stall_cycles", if_stall_cnt, 2 * LAT + 5);
        if (issue_log.size() == 2) begin
            ceq("conflict_first_addr", issue_log[0].addr, 32'h200);
            ceq("conflict_first_cyc", issue_log[0].cyc - t0, 1);
            ceq("conflict_second_addr", issue_log[1].addr, 32'h44);
            ceq("conflict_second_cyc", issue_log[1].cyc - t0, LAT + 4);
        end else begin
            ceq("conflict_issue_cnt", issue_log.size(), 2);
        end

        // alternation with both stages requesting back to back
        do_reset();
        ack_log.delete();
        fork
            begin
                d_access(1'b0, 32'h800, 32'h0, t0d, latd);
                d_access(1'b1, 32'h804, 32'h1234_5678, t0d, latd);
                d_idle(1);
            end
            begin
                if_fetch(32'h80, t0, lat);
                if_fetch(32'h84, t0, lat);
                if_idle(1);
            end
        join
        exp_owner = '{1'b1, 1'b0, 1'b1, 1'b0};
        ceq("alt_ack_cnt", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            ceq($sformatf("alt_owner_%0d", i), {31'h0, ack_log[i].is_d}, {31'h0, exp_owner[i]});

        // reset during WAIT of a fetch
        do_reset();
        ack_log.delete();
        @(posedge CLK); #1;
        IF_Req = 1'b1; IF_Addr = 32'h48;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b1; IF_Req = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_vals("midreset");
        repeat (LAT + 3) @(negedge CLK);
        ceq("midreset_no_ack", ack_log.size(), 0);
        if_fetch(32'h48, t0, lat);
        ceq("midreset_refetch_latency", lat, LAT + 2);
        if_idle(1);

        // randomized traffic
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int g;
                    int it0, ilat;
                    g = $urandom_range(0, 3);
                    if (g > 0) if_idle(g);
                    if_fetch(32'($urandom_range(0, 511)) << 2, it0, ilat);
                    chk("rand_if_latency", ilat >= LAT + 2 && ilat <= 2 * LAT + 5,
                        32'(ilat), 32'(2 * LAT + 5));
                end
                if_idle(1);
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    int g;
                    int dt0, dlat;
                    g = $urandom_range(0, 3);
                    if (g > 0) d_idle(g);
                    d_access(1'($urandom_range(0, 1)),
                             32'h800 + (32'($urandom_range(0, 15)) << 2),
                             $urandom, dt0, dlat);
                    chk("rand_d_latency", dlat >= LAT + 2 && dlat <= 2 * LAT + 5,
                        32'(dlat), 32'(2 * LAT + 5));
                end
                d_idle(1);
            end
        join
        repeat (4) @(negedge CLK);
        ceq("rand_if_queue_empty", if_exp.size(), 0);
        ceq("rand_d_queue_empty", d_exp.size(), 0);

        // latency extremes: MEM_LAT = 1 and 15
        @(posedge CLK); #1;
        x_addr = 32'h40;
        x_req[0] = 1'b1; x_req[1] = 1'b1;
        t0 = cyc;
        xlat[0] = -1; xlat[1] = -1;
        xdone[0] = 1'b0; xdone[1] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                if (x_ack[i] && !xdone[i]) begin
                    xlat[i] = cyc - t0;
                    xdone[i] = 1'b1;
                    ceq($sformatf("lat_build_%0d_rdata", i), x_rdata[i], 32'h2008_0005);
                end
            end
            @(posedge CLK); #1;
            for (int i = 0; i < 2; i++) if (xdone[i]) x_req[i] = 1'b0;
        end
        ceq("lat1_ack_cycle", xlat[0], 3);
        ceq("lat15_ack_cycle", xlat[1], 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
